// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad front end.
package keypad_pkg;

  // Widest key code any supported geometry can produce.
  localparam int KEY_CODE_MAX_W = 16;

  typedef struct packed {
    logic                      pressed;
    logic [KEY_CODE_MAX_W-1:0] code;
  } key_state_t;

  localparam key_state_t KEY_NONE = '{pressed: 1'b0, code: '0};

  typedef enum logic {
    ST_IDLE,
    ST_HELD
  } key_fsm_t;

  function automatic int keycode_w(input int rows, input int cols, input int n_ops);
    return $clog2(rows * cols + n_ops);
  endfunction

  // Operator pins are numbered after the last matrix key.
  function automatic int op_code_base(input int rows, input int cols);
    return rows * cols;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through event queue with occupancy count.
module key_fifo #(
  parameter  int WIDTH = 5,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             pop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop     = !empty && rd_ready;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (!do_push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/keypad_scanner.sv
// Keypad front end: row scan, per-frame key selection, multi-frame debounce
// and buffered key events with sticky overflow.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter  int ROWS            = 4,
  parameter  int COLS            = 4,
  parameter  int N_OPS           = 6,
  parameter  int DEBOUNCE_FRAMES = 2,
  parameter  int FIFO_DEPTH      = 4,
  parameter  int EVENT_ON_PRESS  = 0,
  localparam int KW              = keycode_w(ROWS, COLS, N_OPS),
  localparam int CW              = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [ROWS-1:0]  o_word_lines,
  input  logic [COLS-1:0]  i_bit_lines,
  input  logic [N_OPS-1:0] i_op_pins,
  output logic [KW-1:0]    o_data,
  output logic             o_data_valid,
  input  logic             i_read_ready,
  output logic [CW-1:0]    o_count,
  output logic             o_overflow,
  input  logic             i_overflow_clr
);

  localparam int         RW      = $clog2(ROWS);
  localparam int         OP_BASE = op_code_base(ROWS, COLS);
  localparam logic [3:0] DEB     = 4'(DEBOUNCE_FRAMES);

  logic [RW-1:0]             row_q;
  logic                      frame_start;
  logic                      frame_end;
  logic                      op_hit;
  logic                      mat_hit;
  logic [KEY_CODE_MAX_W-1:0] op_code;
  logic [KEY_CODE_MAX_W-1:0] mat_code;
  key_state_t                prior;
  logic                      prior_op;
  key_state_t                sel;
  logic                      sel_op;
  key_state_t                acc_p0;
  logic                      acc_op_p0;
  key_state_t                cand_p1;
  logic [3:0]                cnt_p1;
  key_state_t                cand_nx;
  logic [3:0]                cnt_nx;
  key_fsm_t                  state_q;
  key_fsm_t                  state_nx;
  logic [KW-1:0]             held_code_p2;
  key_state_t                accepted;
  logic                      accept;
  logic                      push;
  logic [KW-1:0]             push_code;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_pop;
  logic                      drop;

  // Row scan: one-hot drive decoded from the registered counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           row_q <= '0;
    else if (row_q == RW'(ROWS - 1))   row_q <= '0;
    else                               row_q <= row_q + 1'b1;
  end

  assign o_word_lines = ROWS'(1) << row_q;
  assign frame_start  = (row_q == '0);
  assign frame_end    = (row_q == RW'(ROWS - 1));

  always_comb begin
    op_hit  = 1'b0;
    op_code = '0;
    for (int j = N_OPS - 1; j >= 0; j--) begin
      if (i_op_pins[j]) begin
        op_hit  = 1'b1;
        op_code = KEY_CODE_MAX_W'(OP_BASE + j);
      end
    end
    mat_hit  = 1'b0;
    mat_code = '0;
    for (int c = 0; c < COLS; c++) begin
      if (i_bit_lines[c]) begin
        mat_hit  = 1'b1;
        mat_code = KEY_CODE_MAX_W'(int'(row_q) * COLS + c);
      end
    end
  end

  // Stage p0: frame accumulation; row 0 starts from an empty frame.
  always_comb begin
    prior    = frame_start ? KEY_NONE : acc_p0;
    prior_op = frame_start ? 1'b0 : acc_op_p0;
    sel      = prior;
    sel_op   = prior_op;
    if (op_hit && (!prior_op || op_code < prior.code)) begin
      sel.pressed = 1'b1;
      sel.code    = op_code;
      sel_op      = 1'b1;
    end else if (mat_hit && !prior.pressed) begin
      sel.pressed = 1'b1;
      sel.code    = mat_code;
    end
  end

  always_ff @(posedge clk) begin
    acc_p0    <= sel;
    acc_op_p0 <= sel_op;
  end

  // Stage p1: debounce candidate, updated on the frame-end edge.
  always_comb begin
    if (sel == cand_p1) begin
      cand_nx = cand_p1;
      cnt_nx  = (cnt_p1 >= DEB) ? cnt_p1 : cnt_p1 + 1'b1;
    end else begin
      cand_nx = sel;
      cnt_nx  = 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_p1 <= KEY_NONE;
      cnt_p1  <= '0;
    end else if (frame_end) begin
      cand_p1 <= cand_nx;
      cnt_p1  <= cnt_nx;
    end
  end

  assign accepted = (state_q == ST_HELD) ? '{pressed: 1'b1, code: KEY_CODE_MAX_W'(held_code_p2)}
                                         : KEY_NONE;
  assign accept   = frame_end && (cnt_nx == DEB) && (cand_nx != accepted);

  // Stage p2: accepted key state and event generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    if (accept) state_nx = cand_nx.pressed ? ST_HELD : ST_IDLE;
  end

  always_comb begin
    push      = 1'b0;
    push_code = '0;
    if (accept) begin
      if (EVENT_ON_PRESS != 0) begin
        push      = cand_nx.pressed;
        push_code = cand_nx.code[KW-1:0];
      end else begin
        push      = (state_q == ST_HELD);
        push_code = held_code_p2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) held_code_p2 <= cand_nx.code[KW-1:0];
  end

  key_fifo #(
    .WIDTH (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_code),
    .rd_ready  (i_read_ready),
    .rd_data   (o_data),
    .count     (o_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .pop       (fifo_pop)
  );

  assign o_data_valid = !fifo_empty;
  assign drop         = push && fifo_full && !fifo_pop;

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 o_overflow <= 1'b0;
    else if (drop)           o_overflow <= 1'b1;
    else if (i_overflow_clr) o_overflow <= 1'b0;
  end

endmodule
